// File: rtl/opl2_op_sequencer.sv
// OPL2 operator time-slot sequencer: divides clk down to the sample rate and
// issues the operator slots of each sample with channel/carrier/rhythm decode.
//
// state | meaning
// IDLE  | waiting for sample_clk_en
// ISSUE | op_valid high with the current slot outputs
// GAP   | spacing cycles between two slots
// DONE  | ops_done pulse after the last slot
module opl2_op_sequencer #(
  parameter int CLK_DIV_COUNT  = 494,
  parameter int NUM_OPS        = 18,
  parameter int OP_SLOT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       ic_n,
  input  logic       rhythm_en,
  output logic       sample_clk_en,
  output logic       op_valid,
  output logic [4:0] op_num,
  output logic [3:0] ch_num,
  output logic       op_is_carrier,
  output logic [2:0] op_type,
  output logic       busy,
  output logic       ops_done
);

  localparam int DIV_W = (CLK_DIV_COUNT > 2) ? $clog2(CLK_DIV_COUNT) : 1;
  localparam int GAP_W = (OP_SLOT_CYCLES > 2) ? $clog2(OP_SLOT_CYCLES - 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV_COUNT - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV_COUNT - 2);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((OP_SLOT_CYCLES >= 2) ? OP_SLOT_CYCLES - 2 : 0);
  localparam logic [4:0]       LAST_OP  = 5'(NUM_OPS - 1);

  if (OP_SLOT_CYCLES < 1) begin : g_bad_slot
    $fatal(1, "opl2_op_sequencer: OP_SLOT_CYCLES must be at least 1");
  end
  if (NUM_OPS < 1 || NUM_OPS > 18) begin : g_bad_ops
    $fatal(1, "opl2_op_sequencer: NUM_OPS must be 1..18");
  end
  if (CLK_DIV_COUNT < NUM_OPS * OP_SLOT_CYCLES + 2) begin : g_bad_div
    $fatal(1, "opl2_op_sequencer: CLK_DIV_COUNT too small for the slot schedule");
  end

  typedef enum logic [2:0] {
    OP_NORMAL     = 3'd0,
    OP_BASS_DRUM  = 3'd1,
    OP_HI_HAT     = 3'd2,
    OP_TOM_TOM    = 3'd3,
    OP_SNARE_DRUM = 3'd4,
    OP_TOP_CYMBAL = 3'd5
  } operator_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             rhythm_lat;

  logic [4:0] slot_nxt;
  logic       rhy_nxt;
  logic [3:0] ch_nxt;
  logic       car_nxt;
  operator_t  type_nxt;

  // Slots run in groups of six: three modulators then three carriers of
  // three consecutive channels.
  function automatic logic [3:0] slot_ch(input logic [4:0] slot);
    logic [4:0] grp;
    logic [4:0] w;
    grp = slot / 5'd6;
    w   = slot - grp * 5'd6;
    if (w >= 5'd3) w = w - 5'd3;
    return 4'(grp * 5'd3 + w);
  endfunction

  function automatic logic slot_carrier(input logic [4:0] slot);
    return (slot % 5'd6) >= 5'd3;
  endfunction

  function automatic operator_t slot_type(input logic [4:0] slot, input logic rhy);
    operator_t ty;
    ty = OP_NORMAL;
    if (rhy) begin
      case (slot)
        5'd12, 5'd15: ty = OP_BASS_DRUM;
        5'd13:        ty = OP_HI_HAT;
        5'd14:        ty = OP_TOM_TOM;
        5'd16:        ty = OP_SNARE_DRUM;
        5'd17:        ty = OP_TOP_CYMBAL;
        default:      ty = OP_NORMAL;
      endcase
    end
    return ty;
  endfunction

  // Decode of the slot about to be issued; rhythm comes straight from the
  // input on the first slot because the latch is loaded in the same cycle.
  always_comb begin
    slot_nxt = (state == S_IDLE) ? 5'd0 : op_num + 5'd1;
    rhy_nxt  = (state == S_IDLE) ? rhythm_en : rhythm_lat;
    ch_nxt   = slot_ch(slot_nxt);
    car_nxt  = slot_carrier(slot_nxt);
    type_nxt = slot_type(slot_nxt, rhy_nxt);
  end

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      div_cnt       <= '0;
      sample_clk_en <= 1'b0;
    end else begin
      div_cnt       <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      sample_clk_en <= (div_cnt == DIV_PRE);
    end
  end

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      state         <= S_IDLE;
      gap_cnt       <= '0;
      rhythm_lat    <= 1'b0;
      op_valid      <= 1'b0;
      op_num        <= '0;
      ch_num        <= '0;
      op_is_carrier <= 1'b0;
      op_type       <= '0;
      busy          <= 1'b0;
      ops_done      <= 1'b0;
    end else begin
      op_valid <= 1'b0;
      ops_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (sample_clk_en) begin
            rhythm_lat    <= rhythm_en;
            op_num        <= slot_nxt;
            ch_num        <= ch_nxt;
            op_is_carrier <= car_nxt;
            op_type       <= type_nxt;
            op_valid      <= 1'b1;
            busy          <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (OP_SLOT_CYCLES == 1) begin
            if (op_num == LAST_OP) begin
              busy     <= 1'b0;
              ops_done <= 1'b1;
              state    <= S_DONE;
            end else begin
              op_num        <= slot_nxt;
              ch_num        <= ch_nxt;
              op_is_carrier <= car_nxt;
              op_type       <= type_nxt;
              op_valid      <= 1'b1;
            end
          end else begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (op_num == LAST_OP) begin
              busy     <= 1'b0;
              ops_done <= 1'b1;
              state    <= S_DONE;
            end else begin
              op_num        <= slot_nxt;
              ch_num        <= ch_nxt;
              op_is_carrier <= car_nxt;
              op_type       <= type_nxt;
              op_valid      <= 1'b1;
              state         <= S_ISSUE;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The divider guarantees a new sample never starts while slots are pending.
  a_sample_in_idle: assert property (@(posedge clk) disable iff (!ic_n)
    sample_clk_en |-> state == S_IDLE);

endmodule

// File: tb/tb_opl2_op_sequencer.sv
// Self-checking bench for opl2_op_sequencer: a default-rate instance and a
// back-to-back (one cycle per slot) instance checked against a timing model.
module tb_opl2_op_sequencer;

  localparam int N_A = 494;
  localparam int S_A = 16;
  localparam int N_B = 20;
  localparam int S_B = 1;

  logic clk;
  logic ic_n;
  logic rhythm_en;

  logic       a_sce, a_vld, a_car, a_busy, a_done;
  logic [4:0] a_op;
  logic [3:0] a_ch;
  logic [2:0] a_typ;
  logic       b_sce, b_vld, b_car, b_busy, b_done;
  logic [4:0] b_op;
  logic [3:0] b_ch;
  logic [2:0] b_typ;

  opl2_op_sequencer #(.CLK_DIV_COUNT(N_A), .NUM_OPS(18), .OP_SLOT_CYCLES(S_A)) dut_a (
    .clk(clk), .ic_n(ic_n), .rhythm_en(rhythm_en),
    .sample_clk_en(a_sce), .op_valid(a_vld), .op_num(a_op), .ch_num(a_ch),
    .op_is_carrier(a_car), .op_type(a_typ), .busy(a_busy), .ops_done(a_done)
  );

  opl2_op_sequencer #(.CLK_DIV_COUNT(N_B), .NUM_OPS(18), .OP_SLOT_CYCLES(S_B)) dut_b (
    .clk(clk), .ic_n(ic_n), .rhythm_en(rhythm_en),
    .sample_clk_en(b_sce), .op_valid(b_vld), .op_num(b_op), .ch_num(b_ch),
    .op_is_carrier(b_car), .op_type(b_typ), .busy(b_busy), .ops_done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int t = 0;
  bit rhy_a = 1'b0;
  bit rhy_b = 1'b0;
  int pulses_a = 0;
  int pulses_b = 0;

  int ch_tbl   [18] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5, 6, 7, 8, 6, 7, 8};
  int car_tbl  [18] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
  int type_tbl [18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 1, 4, 5};
  int exp_rtyp [6]  = '{1, 2, 3, 1, 4, 5};

  logic [3:0] cap_ch  [32];
  logic       cap_car [32];
  logic [2:0] cap_typ [32];
  int t_sce1, t_sce2, t_op0, t_op17, t_done, t_busy_first, t_busy_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycle t after reset release: samples start every n cycles from n-1, and
  // within a period the slot schedule occupies offsets 0 .. 18*osc.
  function automatic void model(input int tc, input int n, input int osc,
                                output bit sce, output bit vld, output bit bsy,
                                output bit dne, output int op);
    int r;
    sce = (tc % n) == n - 1;
    vld = 1'b0; bsy = 1'b0; dne = 1'b0; op = 0;
    if (tc >= n) begin
      r = tc % n;
      if (r < 18 * osc) begin
        bsy = 1'b1;
        if (r % osc == 0) begin
          vld = 1'b1;
          op  = r / osc;
        end
      end
      dne = (r == 18 * osc);
    end
  endfunction

  task automatic check_dut(input string tag, input int n, input int osc, input bit rhy,
                           input logic sce, input logic vld, input logic [4:0] opn,
                           input logic [3:0] ch, input logic car, input logic [2:0] typ,
                           input logic bsy, input logic dne, inout int pulses);
    bit e_sce, e_vld, e_busy, e_done;
    int e_op;
    model(t, n, osc, e_sce, e_vld, e_busy, e_done, e_op);
    check({tag, ".sample_clk_en"}, 32'(sce), 32'(e_sce));
    check({tag, ".op_valid"},      32'(vld), 32'(e_vld));
    check({tag, ".busy"},          32'(bsy), 32'(e_busy));
    check({tag, ".ops_done"},      32'(dne), 32'(e_done));
    if (e_vld) begin
      check({tag, ".op_num"},        32'(opn), 32'(e_op));
      check({tag, ".ch_num"},        32'(ch),  32'(ch_tbl[e_op]));
      check({tag, ".op_is_carrier"}, 32'(car), 32'(car_tbl[e_op]));
      check({tag, ".op_type"},       32'(typ), rhy ? 32'(type_tbl[e_op]) : 32'd0);
    end
    if (vld === 1'b1) pulses++;
    if (e_done) begin
      check({tag, ".pulses_per_sample"}, 32'(pulses), 32'd18);
      pulses = 0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".A.sample_clk_en"}, 32'(a_sce), 32'd0);
    check({tag, ".A.op_valid"},      32'(a_vld), 32'd0);
    check({tag, ".A.op_num"},        32'(a_op),  32'd0);
    check({tag, ".A.ch_num"},        32'(a_ch),  32'd0);
    check({tag, ".A.op_is_carrier"}, 32'(a_car), 32'd0);
    check({tag, ".A.op_type"},       32'(a_typ), 32'd0);
    check({tag, ".A.busy"},          32'(a_busy), 32'd0);
    check({tag, ".A.ops_done"},      32'(a_done), 32'd0);
    check({tag, ".B.op_valid"},      32'(b_vld), 32'd0);
    check({tag, ".B.busy"},          32'(b_busy), 32'd0);
    check({tag, ".B.ops_done"},      32'(b_done), 32'd0);
  endtask

  task automatic clear_marks();
    t_sce1 = -1; t_sce2 = -1; t_op0 = -1; t_op17 = -1;
    t_done = -1; t_busy_first = -1; t_busy_last = -1;
  endtask

  // One clock cycle: compare both instances, then optionally move rhythm_en.
  task automatic step(input bit set_r, input bit r_val);
    @(negedge clk);
    check_dut("A", N_A, S_A, rhy_a, a_sce, a_vld, a_op, a_ch, a_car, a_typ, a_busy, a_done, pulses_a);
    check_dut("B", N_B, S_B, rhy_b, b_sce, b_vld, b_op, b_ch, b_car, b_typ, b_busy, b_done, pulses_b);
    if (a_vld === 1'b1) begin
      cap_ch[a_op]  = a_ch;
      cap_car[a_op] = a_car;
      cap_typ[a_op] = a_typ;
      if (t_op0 < 0) t_op0 = t;
      if (a_op == 5'd17 && t_op17 < 0) t_op17 = t;
    end
    if (a_sce === 1'b1) begin
      if (t_sce1 < 0) t_sce1 = t;
      else if (t_sce2 < 0) t_sce2 = t;
    end
    if (a_done === 1'b1 && t_done < 0) t_done = t;
    if (a_busy === 1'b1) begin
      if (t_busy_first < 0) t_busy_first = t;
      t_busy_last = t;
    end
    if (set_r) rhythm_en = r_val;
    if (t % N_A == N_A - 1) rhy_a = rhythm_en;
    if (t % N_B == N_B - 1) rhy_b = rhythm_en;
    t++;
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    bit found;
    ic_n = 1'b0;
    rhythm_en = 1'b0;
    clear_marks();
    repeat (3) @(negedge clk);
    check_zero("reset");

    @(posedge clk);
    #2 ic_n = 1'b1;
    t = 0;

    // Sample 1, rhythm off: schedule timing and slot decode.
    while (t < 978) step(1'b0, 1'b0);
    check("first_sample_clk_en_cycle", 32'(t_sce1), 32'd493);
    check("op0_cycle", 32'(t_op0), 32'd494);
    check("op17_cycle", 32'(t_op17), 32'd766);
    check("busy_first_cycle", 32'(t_busy_first), 32'd494);
    check("busy_last_cycle", 32'(t_busy_last), 32'd781);
    check("ops_done_cycle", 32'(t_done), 32'd782);
    check("op4_ch", 32'(cap_ch[4]), 32'd1);
    check("op4_carrier", 32'(cap_car[4]), 32'd1);
    check("op9_ch", 32'(cap_ch[9]), 32'd3);
    check("op9_carrier", 32'(cap_car[9]), 32'd1);
    check("op14_ch", 32'(cap_ch[14]), 32'd8);
    check("op14_carrier", 32'(cap_car[14]), 32'd0);
    check("op17_ch", 32'(cap_ch[17]), 32'd8);
    check("op17_carrier", 32'(cap_car[17]), 32'd1);

    // Sample 2: rhythm on before the pulse, dropped during slot 5.
    step(1'b1, 1'b1);
    while (t < 1068) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    while (t < 1300) step(1'b0, 1'b0);
    check("second_sample_clk_en_cycle", 32'(t_sce2), 32'd987);
    for (int i = 0; i < 12; i++) check("rhythm_sample_low_ops_type", 32'(cap_typ[i]), 32'd0);
    for (int i = 0; i < 6; i++) check("rhythm_sample_type", 32'(cap_typ[12 + i]), 32'(exp_rtyp[i]));

    // Sample 3 follows the dropped rhythm bit.
    while (t < 1800) step(1'b0, 1'b0);
    for (int i = 12; i < 18; i++) check("normal_after_rhythm_off_type", 32'(cap_typ[i]), 32'd0);

    // Random rhythm activity against the model.
    while (t < 2800) step($urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)));

    // Reset in the gap after op 7 of instance A.
    found = 1'b0;
    for (int i = 0; i < 2 * N_A && !found; i++) begin
      if (t >= N_A && t % N_A == 120) found = 1'b1;
      else step(1'b0, 1'b0);
    end
    check("reset_point_found", 32'(found), 32'd1);
    @(negedge clk);
    check("pre_reset_busy", 32'(a_busy), 32'd1);
    check("pre_reset_op_num", 32'(a_op), 32'd7);
    ic_n = 1'b0;
    #1;
    check_zero("mid_gap_reset");
    repeat (2) @(negedge clk);
    check_zero("held_reset");

    @(posedge clk);
    #2 ic_n = 1'b1;
    t = 0;
    rhy_a = 1'b0;
    rhy_b = 1'b0;
    pulses_a = 0;
    pulses_b = 0;
    clear_marks();
    while (t < 1300) step($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)));
    check("post_reset_first_sample_clk_en", 32'(t_sce1), 32'd493);
    check("post_reset_op0_cycle", 32'(t_op0), 32'd494);
    check("post_reset_second_sample_clk_en", 32'(t_sce2), 32'd987);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/opl2_op_sequencer.md
Name: opl2_op_sequencer

Overview:
- Time-slot scheduler for the shared OPL2 operator datapath.
- Divides clk by CLK_DIV_COUNT to produce the sample-rate enable.
- At each sample start, issues the 18 operator slots in fixed order, spaced OP_SLOT_CYCLES apart.
- Each slot carries: operator number, channel number, carrier flag and operator type (rhythm-mode aware). Phase, envelope and operator pipelines consume these directly.

Parameters:
- CLK_DIV_COUNT, 494: clk cycles per sample period (24.576 MHz / 494 = 49.749 kHz).
- NUM_OPS, 18: operator slots per sample.
- OP_SLOT_CYCLES, 16: clk cycles between successive op_valid pulses. Must be ≥1.
- Elaboration-time check: CLK_DIV_COUNT ≥ NUM_OPS*OP_SLOT_CYCLES + 2, else $fatal.

Ports:
- clk  in  1  audio clock, 24.576 MHz
- ic_n  in  1  asynchronous active-low reset
- rhythm_en  in  1  rhythm-mode bit from register 0xBD[5]; sampled only at sample start
- sample_clk_en  out  1  one-cycle pulse every CLK_DIV_COUNT cycles
- op_valid  out  1  one-cycle pulse per operator slot
- op_num  out  5  operator slot 0..17, valid with op_valid
- ch_num  out  4  channel 0..8, valid with op_valid
- op_is_carrier  out  1  1 = carrier (second operator of channel)
- op_type  out  3  operator_t encoding: 0 NORMAL, 1 BASS_DRUM, 2 HI_HAT, 3 TOM_TOM, 4 SNARE_DRUM, 5 TOP_CYMBAL
- busy  out  1  high while slots of the current sample are in progress
- ops_done  out  1  one-cycle pulse after the last slot completes

Behaviour:
- Reset (ic_n low, asynchronous):
  - All outputs 0; divider count 0; slot counters 0; FSM IDLE; latched rhythm 0.
  - Takes effect immediately, including mid-sequence; the partial sample is abandoned with no ops_done.
- Divider:
  - div_cnt counts 0..CLK_DIV_COUNT-1 and wraps. It free-runs regardless of FSM state.
  - sample_clk_en is registered and high in the cycle where div_cnt == CLK_DIV_COUNT-1.
  - Counting the first cycle after reset release as cycle 0, the first pulse is in cycle CLK_DIV_COUNT-1 (493), then every 494 cycles.
- FSM states IDLE, ISSUE, GAP, DONE:
  - IDLE: on sample_clk_en, latch rhythm_en, set op_num = 0, go to ISSUE.
  - ISSUE: op_valid = 1 for one cycle with the current slot outputs, busy = 1. If OP_SLOT_CYCLES == 1, step directly to the next ISSUE (or DONE after slot 17); otherwise go to GAP with gap_cnt = 0.
  - GAP: busy = 1, op_valid = 0. Count to OP_SLOT_CYCLES-2. Then, if op_num == NUM_OPS-1, go to DONE; else increment op_num and go to ISSUE.
  - DONE: ops_done = 1 for one cycle, busy = 0, go to IDLE.
- Latency: op 0 op_valid appears in the cycle after sample_clk_en. Op k appears OP_SLOT_CYCLES*k cycles later.
- Slot decode, registered and aligned with op_valid:
  - group = op_num/6, w = op_num%6.
  - ch_num = 3*group + (w%3).
  - op_is_carrier = (w ≥ 3).
- op_type: NORMAL unless latched rhythm = 1. With rhythm = 1:
  - ops 12 and 15 → BASS_DRUM
  - op 13 → HI_HAT
  - op 14 → TOM_TOM
  - op 16 → SNARE_DRUM
  - op 17 → TOP_CYMBAL
- rhythm_en changes mid-sample have no effect until the next sample_clk_en.
- Between slots, op_num/ch_num/op_is_carrier/op_type hold their last values. Consumers qualify with op_valid only.
- sample_clk_en arriving outside IDLE cannot occur given the elaboration check; the RTL carries an assertion for it.

Test Plan:
- Reset release, defaults → sample_clk_en first high at cycle 493, next at 987; op_valid for op 0 at 494 and op 17 at 766; busy high 494..781; ops_done at 782; exactly 18 op_valid pulses per sample.
- Slot decode check → op 4: ch 1, carrier 1. Op 9: ch 3, carrier 1. Op 14: ch 8, carrier 0. Op 17: ch 8, carrier 1.
- rhythm_en = 1 before a pulse → op_type sequence for ops 12..17 is 1, 2, 3, 1, 4, 5; ops 0..11 are 0. Toggling rhythm_en to 0 during slot 5 leaves that sample unchanged and the next sample all-NORMAL.
- ic_n asserted during the GAP after op 7 → all outputs 0 immediately, no ops_done. After release, the next sample_clk_en is 493 cycles later and the sequence restarts at op 0.
- OP_SLOT_CYCLES = 1, CLK_DIV_COUNT = 20 → op_valid on 18 consecutive cycles following the pulse, then ops_done; a bench with CLK_DIV_COUNT = 19 fails elaboration.
